// File: rtl/triad_tx_arbiter_pkg.sv
// rtl/triad_tx_arbiter_pkg.sv - shared constants, state encoding and helpers for the triad transmit arbiter
package triad_tx_arbiter_pkg;

  localparam int TRIAD_W       = 68;
  localparam int CH_W          = 3;
  localparam int BAUD_DIV      = 104;
  localparam int FRAME_BYTES   = 16;
  localparam int BITS_PER_BYTE = 10;
  localparam int HOLDOFF_MARGIN = 360;
  // One full 16-byte UART frame at 115200 baud from a 12 MHz clock, plus slack
  localparam int HOLDOFF_DEFAULT = FRAME_BYTES * BITS_PER_BYTE * BAUD_DIV + HOLDOFF_MARGIN;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_HOLDOFF  = 2'd2
  } arb_state_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/triad_tx_arbiter_rr_pick.sv
// rtl/triad_tx_arbiter_rr_pick.sv - combinational round-robin picker over the slot full flags
module triad_tx_arbiter_rr_pick
  import triad_tx_arbiter_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] i_full,
  input  logic [CH_W-1:0] i_last,
  output logic            o_hit,
  output logic [CH_W-1:0] o_index
);

  // Channels above the last grant take priority, then wrap to the lowest indices
  always_comb begin
    o_hit   = 1'b0;
    o_index = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!o_hit && i_full[i] && (CH_W'(i) > i_last)) begin
        o_hit   = 1'b1;
        o_index = CH_W'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!o_hit && i_full[i] && (CH_W'(i) <= i_last)) begin
        o_hit   = 1'b1;
        o_index = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/triad_tx_arbiter.sv
// rtl/triad_tx_arbiter.sv - shares one UART frame transmitter between N triad decoder channels
module triad_tx_arbiter
  import triad_tx_arbiter_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
  parameter int ACK_TIMEOUT    = 64
) (
  input  logic                    clk_12MHz,
  input  logic                    rstn,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [TRIAD_W*N_CH-1:0] ch_triad,
  output logic [N_CH-1:0]         ch_ack,
  output logic                    tx_data_availible,
  output logic [TRIAD_W-1:0]      tx_triad_data,
  input  logic                    tx_reset_pulse_identifier,
  output logic [CH_W-1:0]         tx_chan,
  output logic [7:0]              drop_count,
  output logic                    ack_timeout_err
);

  localparam int CNT_MAX = (HOLDOFF_CYCLES > ACK_TIMEOUT) ? HOLDOFF_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CH_W-1:0] LAST_INIT = CH_W'(N_CH - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_txav, w_txav_nxt;
  logic               w_grant;
  logic               w_timeout;

  logic [TRIAD_W-1:0] r_slot [N_CH];
  logic [N_CH-1:0]    r_full;
  logic [N_CH-1:0]    w_clr;
  logic [N_CH-1:0]    w_drop;
  logic [3:0]         w_drop_n;
  logic [TRIAD_W-1:0] w_sel;

  logic               w_hit;
  logic [CH_W-1:0]    w_idx;
  logic [CH_W-1:0]    r_last;
  logic [TRIAD_W-1:0] r_tx_data;
  logic [CH_W-1:0]    r_tx_chan;
  logic [N_CH-1:0]    r_ack;
  logic [7:0]         r_drop;
  logic               r_err;

  triad_tx_arbiter_rr_pick #(
    .N_CH (N_CH)
  ) u_rr_pick (
    .i_full  (r_full),
    .i_last  (r_last),
    .o_hit   (w_hit),
    .o_index (w_idx)
  );

  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_txav  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_txav  <= w_txav_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_txav_nxt  = r_txav;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_grant     = 1'b1;
          w_txav_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_reset_pulse_identifier) begin
          w_txav_nxt  = 1'b0;
          w_cnt_nxt   = CNT_W'(HOLDOFF_CYCLES - 1);
          w_state_nxt = ST_HOLDOFF;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_txav_nxt  = 1'b0;
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_txav_nxt  = 1'b0;
      end
    endcase
  end

  // A slot being granted this cycle is vacated, so a strobe into it is a capture, not a loss
  always_comb begin
    w_clr    = '0;
    w_sel    = '0;
    w_drop_n = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_clr[i] = w_grant && (w_idx == CH_W'(i));
      if (w_idx == CH_W'(i)) begin
        w_sel = r_slot[i];
      end
    end
    w_drop = ch_valid & r_full & ~w_clr;
    for (int i = 0; i < N_CH; i++) begin
      w_drop_n = w_drop_n + {3'b000, w_drop[i]};
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (!rstn) begin
      r_full    <= '0;
      r_ack     <= '0;
      r_drop    <= '0;
      r_err     <= 1'b0;
      r_tx_data <= '0;
      r_tx_chan <= '0;
      r_last    <= LAST_INIT;
      for (int i = 0; i < N_CH; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_ack  <= ch_valid;
      r_drop <= sat_add8(r_drop, w_drop_n);
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_grant) begin
        r_tx_data <= w_sel;
        r_tx_chan <= w_idx;
        r_last    <= w_idx;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (ch_valid[i]) begin
          r_slot[i] <= ch_triad[i*TRIAD_W +: TRIAD_W];
          r_full[i] <= 1'b1;
        end else if (w_clr[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  assign ch_ack            = r_ack;
  assign tx_data_availible = r_txav;
  assign tx_triad_data     = r_tx_data;
  assign tx_chan           = r_tx_chan;
  assign drop_count        = r_drop;
  assign ack_timeout_err   = r_err;

endmodule

// File: tb/tb_triad_tx_arbiter.sv
// tb/tb_triad_tx_arbiter.sv - self-checking bench for triad_tx_arbiter with a transmitter stand-in and slot model
module tb_triad_tx_arbiter;

  localparam int N_CH = 4;
  localparam int HOLD = 40;
  localparam int ATO  = 64;
  localparam int TW   = 68;
  localparam logic [TW-1:0] W_SINGLE = 68'h1_2345_6789_ABCD_EF01;

  logic             clk_12MHz = 1'b0;
  logic             rstn = 1'b0;
  logic [N_CH-1:0]  ch_valid = '0;
  logic [TW*N_CH-1:0] ch_triad = '0;
  logic [N_CH-1:0]  ch_ack;
  logic             tx_av;
  logic [TW-1:0]    tx_data;
  logic             tx_ack = 1'b0;
  logic [2:0]       tx_chan;
  logic [7:0]       drop_count;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Reference model: what each slot holds, the round-robin pointer and the expected loss count
  logic          pend [N_CH];
  logic [TW-1:0] pword [N_CH];
  int            last_g = N_CH - 1;
  int            drop_exp = 0;
  logic          prev_av = 1'b0;
  int            stall = 0;
  int            cyc = 0;
  int            m_e;
  int            g_ch [$];
  logic [TW-1:0] g_word [$];
  int            g_time [$];

  // Transmitter stand-in
  logic          ack_en = 1'b1;
  logic          tx_busy = 1'b0;
  int            tx_cnt = 0;
  logic [TW-1:0] tx_latched = '0;
  logic [TW-1:0] rx_q [$];
  int            frames = 0;

  logic [TW-1:0] wa, wb;

  always #5 clk_12MHz = ~clk_12MHz;

  triad_tx_arbiter #(
    .N_CH           (N_CH),
    .HOLDOFF_CYCLES (HOLD),
    .ACK_TIMEOUT    (ATO)
  ) dut (
    .clk_12MHz                 (clk_12MHz),
    .rstn                      (rstn),
    .ch_valid                  (ch_valid),
    .ch_triad                  (ch_triad),
    .ch_ack                    (ch_ack),
    .tx_data_availible         (tx_av),
    .tx_triad_data             (tx_data),
    .tx_reset_pulse_identifier (tx_ack),
    .tx_chan                   (tx_chan),
    .drop_count                (drop_count),
    .ack_timeout_err           (err)
  );

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand68();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  task automatic set_word(input int c, input logic [TW-1:0] w);
    ch_triad[c*TW +: TW] = w;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_12MHz);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk_12MHz);
    rstn = 1'b1;
  endtask

  task automatic clear_logs();
    g_ch.delete();
    g_word.delete();
    g_time.delete();
    rx_q.delete();
    frames = 0;
  endtask

  task automatic wait_grants(input string tag, input int n);
    for (int i = 0; i < 400 && g_ch.size() < n; i++) @(negedge clk_12MHz);
    chk(tag, g_ch.size(), n);
  endtask

  task automatic wait_frames(input string tag, input int n);
    for (int i = 0; i < 200 && frames < n; i++) @(negedge clk_12MHz);
    chk(tag, frames, n);
  endtask

  // Model and monitor, evaluated just after each rising edge
  always @(posedge clk_12MHz) begin
    #1;
    cyc++;
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) pend[i] = 1'b0;
      last_g   = N_CH - 1;
      drop_exp = 0;
      prev_av  = 1'b0;
      stall    = 0;
    end else begin
      if (tx_av && !prev_av) begin
        m_e = -1;
        for (int k = 1; k <= N_CH; k++) begin
          if (m_e < 0 && pend[(last_g + k) % N_CH]) m_e = (last_g + k) % N_CH;
        end
        chk("grant_has_pending", (m_e >= 0), 1'b1);
        if (m_e >= 0) begin
          chk("grant_chan", tx_chan, m_e);
          chk("grant_word", tx_data, pword[m_e]);
          pend[m_e] = 1'b0;
          last_g = m_e;
        end
        g_ch.push_back(int'(tx_chan));
        g_word.push_back(tx_data);
        g_time.push_back(cyc);
        stall = 0;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (ch_valid[i]) begin
          if (pend[i]) drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
          pend[i]  = 1'b1;
          pword[i] = ch_triad[i*TW +: TW];
        end
      end
      chk("ack_echo", ch_ack, ch_valid);
      chk("drop_count", drop_count, drop_exp);
      m_e = 0;
      for (int i = 0; i < N_CH; i++) if (pend[i]) m_e = 1;
      stall = (m_e != 0) ? stall + 1 : 0;
      if (stall > HOLD + ATO + 10) begin
        chk("grant_stall", stall, 0);
        stall = 0;
      end
      prev_av = tx_av;
    end
  end

  // Transmitter: latches the word one cycle after seeing the request, acks on the third cycle
  always @(negedge clk_12MHz) begin
    if (!rstn) begin
      tx_busy = 1'b0;
      tx_ack  = 1'b0;
      tx_cnt  = 0;
    end else if (tx_busy) begin
      tx_cnt++;
      if (tx_cnt == 1) tx_latched = tx_data;
      tx_ack = (tx_cnt == 2);
      if (tx_cnt == 3) begin
        rx_q.push_back(tx_latched);
        frames++;
        tx_busy = 1'b0;
      end
    end else if (ack_en && tx_av) begin
      tx_busy = 1'b1;
      tx_cnt  = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    step(3);
    chk("rst_av", tx_av, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_chan", tx_chan, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", ch_ack, 0);
    rstn = 1'b1;

    // Single word on channel 2
    step(2);
    set_word(2, W_SINGLE);
    ch_valid = 4'b0100;
    @(negedge clk_12MHz);
    ch_valid = '0;
    chk("sw_ack", ch_ack, 4'b0100);
    chk("sw_av_early", tx_av, 0);
    @(negedge clk_12MHz);
    chk("sw_av", tx_av, 1);
    chk("sw_word", tx_data, W_SINGLE);
    chk("sw_chan", tx_chan, 2);
    chk("sw_ack_drop", ch_ack, 0);
    wait_frames("sw_frame", 1);
    chk("sw_rx_word", rx_q[0], W_SINGLE);
    step(HOLD + 20);
    chk("sw_one_frame", frames, 1);
    chk("sw_idle", tx_av, 0);

    // Round-robin from a fresh pointer
    do_reset();
    clear_logs();
    for (int c = 0; c < N_CH; c++) set_word(c, rand68());
    ch_valid = 4'b1111;
    @(negedge clk_12MHz);
    ch_valid = '0;
    wait_grants("rr_count", 4);
    for (int k = 0; k < 4 && k < g_ch.size(); k++) chk("rr_order", g_ch[k], k);
    for (int k = 1; k < 4 && k < g_time.size(); k++)
      chk("rr_gap", ((g_time[k] - g_time[k-1]) >= HOLD), 1'b1);
    step(HOLD + 20);
    set_word(0, rand68());
    set_word(3, rand68());
    ch_valid = 4'b1001;
    @(negedge clk_12MHz);
    ch_valid = '0;
    wait_grants("rr_wrap_count", 6);
    if (g_ch.size() >= 6) begin
      chk("rr_wrap_first", g_ch[4], 0);
      chk("rr_wrap_second", g_ch[5], 3);
    end
    step(HOLD + 20);

    // Overwrite during another channel's holdoff
    do_reset();
    clear_logs();
    set_word(0, rand68());
    ch_valid = 4'b0001;
    @(negedge clk_12MHz);
    ch_valid = '0;
    wait_frames("ow_first", 1);
    wa = rand68();
    wb = rand68();
    set_word(1, wa);
    ch_valid = 4'b0010;
    @(negedge clk_12MHz);
    ch_valid = '0;
    step(2);
    set_word(1, wb);
    ch_valid = 4'b0010;
    @(negedge clk_12MHz);
    ch_valid = '0;
    chk("ow_drop1", drop_count, 1);
    wait_grants("ow_count", 2);
    if (g_ch.size() >= 2) begin
      chk("ow_chan", g_ch[1], 1);
      chk("ow_word", g_word[1], wb);
    end
    for (int n = 0; n < 300; n++) begin
      set_word(2, rand68());
      ch_valid = 4'b0100;
      @(negedge clk_12MHz);
    end
    ch_valid = '0;
    @(negedge clk_12MHz);
    chk("ow_saturate", drop_count, 255);
    step(2 * (HOLD + 20));

    // Strobe into a slot on the cycle it is granted
    do_reset();
    clear_logs();
    wa = rand68();
    wb = rand68();
    set_word(0, wa);
    ch_valid = 4'b0001;
    @(negedge clk_12MHz);
    set_word(0, wb);
    @(negedge clk_12MHz);
    ch_valid = '0;
    chk("sim_av", tx_av, 1);
    chk("sim_old_word", tx_data, wa);
    chk("sim_drop", drop_count, 0);
    wait_grants("sim_count", 2);
    if (g_ch.size() >= 2) begin
      chk("sim_new_chan", g_ch[1], 0);
      chk("sim_new_word", g_word[1], wb);
    end
    chk("sim_drop_after", drop_count, 0);
    step(HOLD + 20);

    // Transmitter never acknowledges
    do_reset();
    clear_logs();
    ack_en = 1'b0;
    set_word(1, rand68());
    set_word(2, rand68());
    ch_valid = 4'b0110;
    @(negedge clk_12MHz);
    ch_valid = '0;
    @(negedge clk_12MHz);
    chk("to_av", tx_av, 1);
    chk("to_chan", tx_chan, 1);
    step(ATO - 1);
    chk("to_av_held", tx_av, 1);
    chk("to_err_early", err, 0);
    @(negedge clk_12MHz);
    chk("to_av_drop", tx_av, 0);
    chk("to_err", err, 1);
    ack_en = 1'b1;
    wait_grants("to_next_count", 2);
    if (g_ch.size() >= 2) chk("to_next_chan", g_ch[1], 2);
    wait_frames("to_next_frame", 1);
    chk("to_err_sticky", err, 1);
    step(HOLD + 20);

    // Reset while in holdoff, with another slot pending
    clear_logs();
    set_word(0, rand68());
    ch_valid = 4'b0001;
    @(negedge clk_12MHz);
    ch_valid = '0;
    wait_frames("rh_frame", 1);
    set_word(1, rand68());
    ch_valid = 4'b0010;
    @(negedge clk_12MHz);
    ch_valid = '0;
    step(5);
    rstn = 1'b0;
    @(negedge clk_12MHz);
    rstn = 1'b1;
    chk("rh_av", tx_av, 0);
    chk("rh_data", tx_data, 0);
    chk("rh_chan", tx_chan, 0);
    chk("rh_drop", drop_count, 0);
    chk("rh_err", err, 0);
    chk("rh_ack", ch_ack, 0);
    step(HOLD + ATO);
    chk("rh_slots_empty", g_ch.size(), 1);
    wa = rand68();
    set_word(3, wa);
    ch_valid = 4'b1000;
    @(negedge clk_12MHz);
    ch_valid = '0;
    @(negedge clk_12MHz);
    chk("rh_av_next", tx_av, 1);
    chk("rh_chan_next", tx_chan, 3);
    chk("rh_word_next", tx_data, wa);
    step(HOLD + 20);

    // Random traffic against the slot model
    do_reset();
    clear_logs();
    for (int n = 0; n < 800; n++) begin
      ch_valid = '0;
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < N_CH; c++) set_word(c, rand68());
        ch_valid = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      end
      @(negedge clk_12MHz);
    end
    ch_valid = '0;
    step(N_CH * (HOLD + 20));
    m_e = 0;
    for (int i = 0; i < N_CH; i++) if (pend[i]) m_e++;
    chk("rand_drained", m_e, 0);
    chk("rand_idle", tx_av, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
